// File: rtl/scan_ray_scheduler_if.sv
// Beam-ingest and ray-tracer channels of scan_ray_scheduler.
// master = ingest/tracer side, slave = scheduler.
interface scan_ray_scheduler_if;
   logic        beam_valid;
   logic        beam_ready;
   logic [31:0] beam_magnitude;
   logic [31:0] beam_angle;
   logic        beam_last;
   logic        ray_start;
   logic [31:0] ray_magnitude;
   logic [31:0] ray_angle;
   logic [31:0] ray_sensor_x;
   logic [31:0] ray_sensor_y;
   logic        ray_busy;

   modport master (
      output beam_valid, beam_magnitude, beam_angle, beam_last, ray_busy,
      input  beam_ready, ray_start, ray_magnitude, ray_angle, ray_sensor_x, ray_sensor_y
   );

   modport slave (
      input  beam_valid, beam_magnitude, beam_angle, beam_last, ray_busy,
      output beam_ready, ray_start, ray_magnitude, ray_angle, ray_sensor_x, ray_sensor_y
   );
endinterface

// File: rtl/scan_ray_scheduler.sv
// Buffers LIDAR beams and issues them one at a time to the bresenham tracer.
// Optional range filter: define SCAN_SCHED_RANGE_FILTER_EN.
module scan_ray_scheduler #(
   parameter int          DEPTH     = 8,
   parameter int          CNT_W     = 16,
   parameter logic [31:0] MAX_RANGE = 32'h0000_4000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 scan_begin,
   input  logic [31:0]          sensor_x,
   input  logic [31:0]          sensor_y,
   scan_ray_scheduler_if.slave  bus,
   output logic                 busy,
   output logic                 scan_done,
   output logic [CNT_W-1:0]     rays_done,
   output logic [CNT_W-1:0]     rays_skipped,
   output logic                 overrun
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} state_e;

   typedef struct packed {
      logic        last;
      logic [31:0] angle;
      logic [31:0] magnitude;
   } beam_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               ray_start_q, ray_start_d;
   logic [31:0]        ray_mag_q, ray_mag_d, ray_ang_q, ray_ang_d;
   logic               last_q, last_d;
   logic [31:0]        pose_x_q, pose_x_d, pose_y_q, pose_y_d;
   logic               scan_open_q, scan_open_d;
   logic               scan_done_q, scan_done_d;
   logic               overrun_q, overrun_d;
   logic [CNT_W-1:0]   rays_done_q, rays_done_d;
`ifdef SCAN_SCHED_RANGE_FILTER_EN
   logic [CNT_W-1:0]   rays_skipped_q, rays_skipped_d;
`endif

   beam_t fifo_mem [DEPTH];
   beam_t head;
   logic  full, empty, push, pop;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign push  = bus.beam_valid && bus.beam_ready;
   assign head  = fifo_mem[rd_ptr_q];

   // NOTE: storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr_q] <= {bus.beam_last, bus.beam_angle, bus.beam_magnitude};
   end

   // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      ray_start_d = ray_start_q;
      ray_mag_d   = ray_mag_q;
      ray_ang_d   = ray_ang_q;
      last_d      = last_q;
      pose_x_d    = pose_x_q;
      pose_y_d    = pose_y_q;
      scan_open_d = scan_open_q;
      scan_done_d = 1'b0;
      overrun_d   = overrun_q;
      rays_done_d = rays_done_q;
`ifdef SCAN_SCHED_RANGE_FILTER_EN
      rays_skipped_d = rays_skipped_q;
`endif

      if (scan_begin) begin
         if (!scan_open_q) begin
            pose_x_d    = sensor_x;
            pose_y_d    = sensor_y;
            scan_open_d = 1'b1;
            rays_done_d = '0;
`ifdef SCAN_SCHED_RANGE_FILTER_EN
            rays_skipped_d = '0;
`endif
         end else begin
            overrun_d = 1'b1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (scan_open_q && !empty) begin
               pop       = 1'b1;
               ray_mag_d = head.magnitude;
               ray_ang_d = head.angle;
               last_d    = head.last;
`ifdef SCAN_SCHED_RANGE_FILTER_EN
               if (head.magnitude == '0 || head.magnitude > MAX_RANGE) begin
                  rays_skipped_d = sat_inc(rays_skipped_q);
                  if (head.last) begin
                     state_d     = DONE;
                     scan_done_d = 1'b1;
                  end
               end else begin
                  state_d     = ISSUE;
                  ray_start_d = 1'b1;
               end
`else
               state_d     = ISSUE;
               ray_start_d = 1'b1;
`endif
            end
         end
         ISSUE: begin
            if (bus.ray_busy) begin
               state_d     = RUN;
               ray_start_d = 1'b0;
            end
         end
         RUN: begin
            if (!bus.ray_busy) begin
               rays_done_d = sat_inc(rays_done_q);
               if (last_q) begin
                  state_d     = DONE;
                  scan_done_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DONE: begin
            scan_open_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ray_start_q <= 1'b0;
         ray_mag_q   <= '0;
         ray_ang_q   <= '0;
         last_q      <= 1'b0;
         pose_x_q    <= '0;
         pose_y_q    <= '0;
         scan_open_q <= 1'b0;
         scan_done_q <= 1'b0;
         overrun_q   <= 1'b0;
         rays_done_q <= '0;
`ifdef SCAN_SCHED_RANGE_FILTER_EN
         rays_skipped_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ray_start_q <= ray_start_d;
         ray_mag_q   <= ray_mag_d;
         ray_ang_q   <= ray_ang_d;
         last_q      <= last_d;
         pose_x_q    <= pose_x_d;
         pose_y_q    <= pose_y_d;
         scan_open_q <= scan_open_d;
         scan_done_q <= scan_done_d;
         overrun_q   <= overrun_d;
         rays_done_q <= rays_done_d;
`ifdef SCAN_SCHED_RANGE_FILTER_EN
         rays_skipped_q <= rays_skipped_d;
`endif
      end
   end

   // beam_ready is held low while reset is asserted so every output reads 0.
   assign bus.beam_ready    = !full && !reset;
   assign bus.ray_start     = ray_start_q;
   assign bus.ray_magnitude = ray_mag_q;
   assign bus.ray_angle     = ray_ang_q;
   assign bus.ray_sensor_x  = pose_x_q;
   assign bus.ray_sensor_y  = pose_y_q;
   assign busy              = (state_q != IDLE) || !empty;
   assign scan_done         = scan_done_q;
   assign rays_done         = rays_done_q;
   assign overrun           = overrun_q;
`ifdef SCAN_SCHED_RANGE_FILTER_EN
   assign rays_skipped      = rays_skipped_q;
`else
   assign rays_skipped      = '0;
`endif

endmodule

// File: tb/tb_scan_ray_scheduler.sv
// Scoreboard bench for scan_ray_scheduler with a behavioural tracer model.
module tb_scan_ray_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        scan_begin;
   logic [31:0] sensor_x, sensor_y;
   logic        busy, scan_done, overrun;
   logic [15:0] rays_done, rays_skipped;

   scan_ray_scheduler_if bus();

   scan_ray_scheduler #(.DEPTH(8), .CNT_W(16)) dut (
      .clock        (clk),
      .reset        (rst),
      .scan_begin   (scan_begin),
      .sensor_x     (sensor_x),
      .sensor_y     (sensor_y),
      .bus          (bus),
      .busy         (busy),
      .scan_done    (scan_done),
      .rays_done    (rays_done),
      .rays_skipped (rays_skipped),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] mag;
      logic [31:0] ang;
   } ray_t;

   ray_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_x = '0, exp_y = '0;
   int          busy_len = 4;
   bit          hold_busy = 1'b0;
   bit          tr_busy = 1'b0;
   int          tr_cnt = 0;
   int          starts = 0;
   int          done_pulses = 0;
   ray_t        cur = '0;

   assign bus.ray_busy = tr_busy;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Tracer model: takes each start, stays busy busy_len cycles (or while held).
   always @(negedge clk) begin
      if (rst) begin
         tr_busy = 1'b0;
         tr_cnt  = 0;
      end else if (tr_busy) begin
         if (!hold_busy) begin
            if (tr_cnt > 1) tr_cnt--;
            else begin
               tr_busy = 1'b0;
               check("ray_mag_stable", bus.ray_magnitude, cur.mag);
               check("ray_ang_stable", bus.ray_angle, cur.ang);
            end
         end
      end else if (bus.ray_start) begin
         starts++;
         check("ray_expected", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            cur = sb.pop_front();
            check("ray_mag", bus.ray_magnitude, cur.mag);
            check("ray_ang", bus.ray_angle, cur.ang);
         end
         check("ray_sensor_x", bus.ray_sensor_x, exp_x);
         check("ray_sensor_y", bus.ray_sensor_y, exp_y);
         tr_busy = 1'b1;
         tr_cnt  = busy_len;
      end
   end

   always @(negedge clk) if (scan_done) done_pulses++;

   task automatic do_scan_begin(input logic [31:0] x, input logic [31:0] y, input bit opens);
      scan_begin = 1'b1;
      sensor_x   = x;
      sensor_y   = y;
      if (opens) begin
         exp_x = x;
         exp_y = y;
      end
      @(negedge clk);
      scan_begin = 1'b0;
   endtask

   task automatic push_beam(input logic [31:0] mag, input logic [31:0] ang, input bit last,
                            input bit issued);
      int n = 0;
      while (!bus.beam_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.beam_ready) begin
         check("push_timeout", bus.beam_ready, 1);
         return;
      end
      bus.beam_valid     = 1'b1;
      bus.beam_magnitude = mag;
      bus.beam_angle     = ang;
      bus.beam_last      = last;
      if (issued) sb.push_back({mag, ang});
      @(negedge clk);
      bus.beam_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!scan_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, scan_done, 1);
      @(negedge clk);
      check({tag, "_pulse"}, scan_done, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      scan_begin = 1'b0;
      sensor_x = '0;
      sensor_y = '0;
      bus.beam_valid = 1'b0;
      bus.beam_magnitude = '0;
      bus.beam_angle = '0;
      bus.beam_last = 1'b0;

      // Reset values
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_ray_start", bus.ray_start, 0);
      check("rst_beam_ready", bus.beam_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_scan_done", scan_done, 0);
      check("rst_rays_done", rays_done, 0);
      check("rst_rays_skipped", rays_skipped, 0);
      check("rst_overrun", overrun, 0);
      check("rst_ray_mag", bus.ray_magnitude, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("ready_after_rst", bus.beam_ready, 1);
      @(negedge clk);

      // Basic three-ray scan
      busy_len = 4;
      do_scan_begin(32'd10, 32'd5, 1'b1);
      push_beam(32'd100, 32'd1, 1'b0, 1'b1);
      push_beam(32'd100, 32'd2, 1'b0, 1'b1);
      push_beam(32'd100, 32'd3, 1'b1, 1'b1);
      wait_done("t1_done", 200);
      @(negedge clk);
      check("t1_rays_done", rays_done, 3);
      check("t1_sb_empty", sb.size(), 0);
      check("t1_done_pulses", done_pulses, 1);
      check("t1_starts", starts, 3);
      check("t1_busy_idle", busy, 0);

      // Backpressure with the tracer held busy
      hold_busy = 1'b1;
      busy_len = 2;
      do_scan_begin(32'd7, 32'd9, 1'b1);
      for (int i = 0; i < 9; i++) push_beam(32'd200 + i, 32'd10 + i, 1'b0, 1'b1);
      check("t2_full", bus.beam_ready, 0);
      check("t2_busy", busy, 1);
      fork
         push_beam(32'd209, 32'd19, 1'b1, 1'b1);
         begin
            repeat (6) @(negedge clk);
            check("t2_still_full", bus.beam_ready, 0);
            hold_busy = 1'b0;
         end
      join
      wait_done("t2_done", 500);
      check("t2_rays_done", rays_done, 10);
      check("t2_sb_empty", sb.size(), 0);
      check("t2_starts", starts, 13);

      // Latency: push at edge k -> ray_start after edge k+1
      busy_len = 3;
      do_scan_begin(32'd20, 32'd21, 1'b1);
      check("t3_ready", bus.beam_ready, 1);
      bus.beam_valid = 1'b1;
      bus.beam_magnitude = 32'd77;
      bus.beam_angle = 32'd5;
      bus.beam_last = 1'b1;
      sb.push_back({32'd77, 32'd5});
      @(negedge clk);
      bus.beam_valid = 1'b0;
      check("t3_lat_k", bus.ray_start, 0);
      @(negedge clk);
      check("t3_lat_k1", bus.ray_start, 1);
      @(negedge clk);
      check("t3_start_drop", bus.ray_start, 0);
      check("t3_busy", busy, 1);
      wait_done("t3_done", 100);
      check("t3_rays_done", rays_done, 1);

      // Overrun: scan_begin while a scan is open
      check("t4_overrun_clear", overrun, 0);
      do_scan_begin(32'd10, 32'd5, 1'b1);
      push_beam(32'd300, 32'd40, 1'b0, 1'b1);
      n = 0;
      while (rays_done != 16'd1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t4_rays1", rays_done, 1);
      do_scan_begin(32'd99, 32'd98, 1'b0);
      check("t4_overrun", overrun, 1);
      check("t4_pose_x", bus.ray_sensor_x, 10);
      check("t4_pose_y", bus.ray_sensor_y, 5);
      check("t4_rays_kept", rays_done, 1);
      push_beam(32'd301, 32'd41, 1'b1, 1'b1);
      wait_done("t4_done", 100);
      check("t4_rays_done", rays_done, 2);
      check("t4_overrun_sticky", overrun, 1);

      // Reset while a ray is running
      hold_busy = 1'b1;
      do_scan_begin(32'd3, 32'd4, 1'b1);
      push_beam(32'd400, 32'd50, 1'b0, 1'b1);
      push_beam(32'd401, 32'd51, 1'b1, 1'b1);
      n = 0;
      while (!bus.ray_start && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("t5_in_run", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_ray_start", bus.ray_start, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_rays_done", rays_done, 0);
      check("t5_rst_overrun", overrun, 0);
      check("t5_rst_ray_mag", bus.ray_magnitude, 0);
      check("t5_rst_sensor_x", bus.ray_sensor_x, 0);
      check("t5_rst_ready", bus.beam_ready, 0);
      sb.delete();
      hold_busy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("t5_ready_after", bus.beam_ready, 1);
      check("t5_fifo_empty", busy, 0);
      @(negedge clk);
      do_scan_begin(32'd1, 32'd2, 1'b1);
      push_beam(32'd500, 32'd60, 1'b0, 1'b1);
      push_beam(32'd501, 32'd61, 1'b1, 1'b1);
      wait_done("t5_done", 200);
      check("t5_rays_done", rays_done, 2);
      check("t5_sb_empty", sb.size(), 0);

`ifdef SCAN_SCHED_RANGE_FILTER_EN
      // Range filter
      do_scan_begin(32'd6, 32'd6, 1'b1);
      push_beam(32'd0, 32'd70, 1'b0, 1'b0);
      push_beam(32'd50, 32'd71, 1'b0, 1'b1);
      push_beam(32'h0000_5000, 32'd72, 1'b1, 1'b0);
      wait_done("t6_done", 200);
      check("t6_rays_done", rays_done, 1);
      check("t6_rays_skipped", rays_skipped, 2);
      check("t6_sb_empty", sb.size(), 0);
`else
      check("t6_skipped_zero", rays_skipped, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
